// File: rtl/ssd_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display between NREQ requesters.
// The winning value is latched and held for DWELL cycles before the next arbitration.
module ssd_display_arbiter #(
    parameter int NREQ  = 4,
    parameter int DWELL = 25000000,
    parameter int CW    = $clog2(DWELL + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_val,
    output logic [NREQ-1:0]      ack,
    output logic [15:0]          disp_val,
    output logic [2:0]           disp_owner,
    output logic                 disp_valid
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [CW-1:0] RELOAD   = CW'(DWELL - 1);
    localparam logic [2:0]    LAST_RST = 3'(NREQ - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          last_q, last_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [15:0]         val_q, val_d;
    logic [2:0]          owner_q, owner_d;
    logic                valid_q, valid_d;

    logic [2*NREQ-1:0]   dbl_s;
    logic [NREQ-1:0]     rot_s;
    logic [3:0]          pos_s;
    logic                found_s;
    logic [2:0]          win_s;
    logic [15:0]         sel_val_s;
    logic [NREQ-1:0]     win_vec_s;
    logic                may_grant_s;

    // Round-robin search: rotate requests so bit 0 is the slot just after the last owner
    always_comb begin
        dbl_s   = {req, req} >> ({1'b0, last_q} + 4'd1);
        rot_s   = dbl_s[NREQ-1:0];
        found_s = 1'b0;
        pos_s   = 4'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found_s && rot_s[j]) begin
                found_s = 1'b1;
                pos_s   = {1'b0, last_q} + 4'd1 + 4'(j);
            end else begin
                found_s = found_s;
            end
        end
        if (pos_s >= 4'(NREQ)) begin
            win_s = 3'(pos_s - 4'(NREQ));
        end else begin
            win_s = pos_s[2:0];
        end
    end

    // Winner's value and one-hot grant vector
    always_comb begin
        sel_val_s = 16'h0000;
        win_vec_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_val_s    = sel_val_s | ((win_s == 3'(i)) ? req_val[16*i +: 16] : 16'h0000);
            win_vec_s[i] = (win_s == 3'(i));
        end
    end

    // Next-state logic: grant when idle or dwell expired, otherwise count the dwell down
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        ack_d       = {NREQ{1'b0}};
        val_d       = val_q;
        owner_d     = owner_q;
        valid_d     = valid_q;
        may_grant_s = (state_q == ST_IDLE) || (cnt_q == {CW{1'b0}});
        if (may_grant_s && found_s) begin
            state_d = ST_HOLD;
            cnt_d   = RELOAD;
            last_d  = win_s;
            ack_d   = win_vec_s;
            val_d   = sel_val_s;
            owner_d = win_s;
            valid_d = 1'b1;
        end else if (may_grant_s) begin
            state_d = ST_IDLE;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            last_q  <= LAST_RST;
            ack_q   <= {NREQ{1'b0}};
            val_q   <= 16'h0000;
            owner_q <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            val_q   <= val_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
        end
    end

    assign ack        = ack_q;
    assign disp_val   = val_q;
    assign disp_owner = owner_q;
    assign disp_valid = valid_q;

endmodule
